// File: rtl/cordic_pkg.sv
// Definitions shared by the rotation and vectoring CORDIC paths: angle
// constants in U(9,7) degrees, the gain-compensation factor, the state
// encoding and the arctan table.
package cordic_pkg;

  localparam int PH_0   = 0;
  localparam int PH_90  = 11520;
  localparam int PH_180 = 23040;
  localparam int PH_270 = 34560;
  localparam int PH_360 = 46080;

  // 1/K = 0.607253 in Q1.15
  localparam int K_Q15 = 19899;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ROT   = 2'd1;
  localparam logic [1:0] ST_SCALE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ROT   = ST_ROT,
    S_SCALE = ST_SCALE,
    S_DONE  = ST_DONE
  } state_t;

  // atan(2^-i) in degrees, U(9,7), rounded to nearest
  function automatic logic [15:0] atan_lut(input logic [3:0] idx);
    logic [15:0] v;
    case (idx)
      4'd0:    v = 16'd5760;
      4'd1:    v = 16'd3400;
      4'd2:    v = 16'd1797;
      4'd3:    v = 16'd912;
      4'd4:    v = 16'd458;
      4'd5:    v = 16'd229;
      4'd6:    v = 16'd115;
      4'd7:    v = 16'd57;
      4'd8:    v = 16'd29;
      4'd9:    v = 16'd14;
      4'd10:   v = 16'd7;
      4'd11:   v = 16'd4;
      4'd12:   v = 16'd2;
      4'd13:   v = 16'd1;
      default: v = 16'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cordic_rot_stage.sv
// One combinational CORDIC micro-rotation; the direction follows the sign of
// the residual angle.
module cordic_rot_stage #(
  parameter int XW = 18,
  parameter int ZW = 17
) (
  input  logic signed [XW-1:0] i_x,
  input  logic signed [XW-1:0] i_y,
  input  logic signed [ZW-1:0] i_z,
  input  logic        [3:0]    i_shift,
  input  logic signed [ZW-1:0] i_atan,
  output logic signed [XW-1:0] o_x,
  output logic signed [XW-1:0] o_y,
  output logic signed [ZW-1:0] o_z
);

  logic signed [XW-1:0] w_xs;
  logic signed [XW-1:0] w_ys;
  logic                 w_dpos;

  assign w_xs   = i_x >>> i_shift;
  assign w_ys   = i_y >>> i_shift;
  assign w_dpos = ~i_z[ZW-1];

  assign o_x = w_dpos ? (i_x - w_ys) : (i_x + w_ys);
  assign o_y = w_dpos ? (i_y + w_xs) : (i_y - w_xs);
  assign o_z = w_dpos ? (i_z - i_atan) : (i_z + i_atan);

endmodule

// File: rtl/cordic_rotation.sv
// Iterative rotation-mode CORDIC: rotates (x_in, y_in) by phase_in degrees,
// one micro-rotation per clock, optional gain compensation, saturated output.
//
// state | meaning
// IDLE  | ready for a new operand, in_ready high
// ROT   | one micro-rotation per cycle, iter 0..ITERATIONS-1
// SCALE | multiply by 1/K (GAIN_COMP=1 only)
// DONE  | result held on x_out/y_out until out_ready
module cordic_rotation
  import cordic_pkg::*;
#(
  parameter int WORD_WIDTH  = 16,
  parameter int PHASE_WIDTH = 16,
  parameter int ITERATIONS  = 15,
  parameter int GAIN_COMP   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [WORD_WIDTH-1:0] x_in,
  input  logic signed [WORD_WIDTH-1:0] y_in,
  input  logic        [PHASE_WIDTH-1:0] phase_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [WORD_WIDTH-1:0] x_out,
  output logic signed [WORD_WIDTH-1:0] y_out,
  output logic                         busy
);

  localparam int XW = WORD_WIDTH + 2;
  localparam int ZW = PHASE_WIDTH + 1;
  localparam int LW = XW + 17;
  localparam logic [3:0]               LAST    = 4'(ITERATIONS - 1);
  localparam logic signed [16:0]       K_S     = 17'(K_Q15);
  localparam logic signed [LW-1:0]     SAT_MAX = LW'((2 ** (WORD_WIDTH - 1)) - 1);
  localparam logic signed [LW-1:0]     SAT_MIN = ~SAT_MAX;

  state_t r_state, w_next;
  logic signed [XW-1:0] r_x, r_y;
  logic signed [ZW-1:0] r_z;
  logic        [3:0]    r_iter;

  logic [PHASE_WIDTH-1:0] w_ph_red, w_ph_off;
  logic [1:0]             w_quad;
  logic signed [XW-1:0]   w_x_ext, w_y_ext, w_x0, w_y0;
  logic signed [ZW-1:0]   w_z0, w_atan, w_nz;
  logic signed [XW-1:0]   w_nx, w_ny;
  logic signed [LW-1:0]   w_px, w_py, w_res_x, w_res_y;
  logic                   w_load_out;

  function automatic logic signed [WORD_WIDTH-1:0] sat(input logic signed [LW-1:0] v);
    if (v > SAT_MAX)      return SAT_MAX[WORD_WIDTH-1:0];
    else if (v < SAT_MIN) return SAT_MIN[WORD_WIDTH-1:0];
    else                  return v[WORD_WIDTH-1:0];
  endfunction

  // Angle wrap, quadrant selection and quadrant pre-rotation of the operand
  always_comb begin
    w_ph_red = phase_in;
    if (phase_in >= PHASE_WIDTH'(PH_360)) w_ph_red = phase_in - PHASE_WIDTH'(PH_360);
    if (w_ph_red < PHASE_WIDTH'(PH_90)) begin
      w_quad = 2'd0; w_ph_off = PHASE_WIDTH'(PH_0);
    end else if (w_ph_red < PHASE_WIDTH'(PH_180)) begin
      w_quad = 2'd1; w_ph_off = PHASE_WIDTH'(PH_90);
    end else if (w_ph_red < PHASE_WIDTH'(PH_270)) begin
      w_quad = 2'd2; w_ph_off = PHASE_WIDTH'(PH_180);
    end else begin
      w_quad = 2'd3; w_ph_off = PHASE_WIDTH'(PH_270);
    end
    w_z0    = {1'b0, w_ph_red - w_ph_off};
    w_x_ext = {{2{x_in[WORD_WIDTH-1]}}, x_in};
    w_y_ext = {{2{y_in[WORD_WIDTH-1]}}, y_in};
    case (w_quad)
      2'd0:    begin w_x0 = w_x_ext;  w_y0 = w_y_ext;  end
      2'd1:    begin w_x0 = -w_y_ext; w_y0 = w_x_ext;  end
      2'd2:    begin w_x0 = -w_x_ext; w_y0 = -w_y_ext; end
      default: begin w_x0 = w_y_ext;  w_y0 = -w_x_ext; end
    endcase
  end

  assign w_atan = ZW'(atan_lut(r_iter));

  cordic_rot_stage #(.XW(XW), .ZW(ZW)) u_stage (
    .i_x     (r_x),
    .i_y     (r_y),
    .i_z     (r_z),
    .i_shift (r_iter),
    .i_atan  (w_atan),
    .o_x     (w_nx),
    .o_y     (w_ny),
    .o_z     (w_nz)
  );

  assign w_px = LW'(r_x) * LW'(K_S);
  assign w_py = LW'(r_y) * LW'(K_S);

  // Result source: scaled vector in SCALE, last micro-rotation otherwise
  always_comb begin
    w_res_x = LW'(w_nx);
    w_res_y = LW'(w_ny);
    if (r_state == S_SCALE) begin
      w_res_x = w_px >>> 15;
      w_res_y = w_py >>> 15;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_ROT;
      S_ROT:   if (r_iter == LAST) w_next = (GAIN_COMP != 0) ? S_SCALE : S_DONE;
      S_SCALE: w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_load_out = (r_state != S_DONE) && (w_next == S_DONE);
  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Working vector, residual angle, iteration counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_iter <= '0;
      x_out  <= '0;
      y_out  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_x    <= w_x0;
          r_y    <= w_y0;
          r_z    <= w_z0;
          r_iter <= '0;
        end
        S_ROT: begin
          r_x    <= w_nx;
          r_y    <= w_ny;
          r_z    <= w_nz;
          r_iter <= r_iter + 4'd1;
        end
        default: ;
      endcase
      if (w_load_out) begin
        x_out <= sat(w_res_x);
        y_out <= sat(w_res_y);
      end
    end
  end

endmodule

// File: tb/tb_cordic_rotation.sv
// Directed bench for cordic_rotation with a scoreboard of ideal rotation
// results computed in floating point.
module tb_cordic_rotation;

  localparam int  TOL = 16;
  localparam real PI  = 3.14159265358979;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b0;
  logic signed [15:0] x_in = '0;
  logic signed [15:0] y_in = '0;
  logic        [15:0] phase_in = '0;
  logic               in_ready, out_valid, busy;
  logic signed [15:0] x_out, y_out;

  cordic_rotation #(
    .WORD_WIDTH(16), .PHASE_WIDTH(16), .ITERATIONS(15), .GAIN_COMP(1)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .phase_in(phase_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; string tag; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk_eq(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_near(input string tag, input int obs, input int exp);
    logic ok;
    ok = ((obs - exp) <= TOL) && ((exp - obs) <= TOL);
    checks++;
    assert (ok === 1'b1) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d+/-%0d", tag, obs, exp, TOL);
    end
  endtask

  function automatic int sat16(input real v);
    int r;
    r = $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  task automatic model(input int x, input int y, input int ph, output int ex, output int ey);
    real th;
    th = (real'(ph) / 128.0) * PI / 180.0;
    ex = sat16(real'(x) * $cos(th) - real'(y) * $sin(th));
    ey = sat16(real'(x) * $sin(th) + real'(y) * $cos(th));
  endtask

  // Present one operand while idle; returns #1 after the accepting edge
  task automatic send(input int x, input int y, input int ph, input string tag);
    exp_t e;
    model(x, y, ph, e.x, e.y);
    e.tag    = tag;
    x_in     = 16'(x);
    y_in     = 16'(y);
    phase_in = 16'(ph);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back(e);
    chk_eq({tag, "_busy"}, int'(busy), 1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    assert (out_valid === 1'b1) else begin
      errors++;
      $error("FAIL out_valid_timeout observed=%0b expected=1", out_valid);
    end
  endtask

  task automatic recv(output int n, output int ox, output int oy);
    exp_t e;
    wait_valid(n);
    ox = int'(x_out);
    oy = int'(y_out);
    chk_eq("sb_pending", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk_near({e.tag, "_x"}, ox, e.x);
      chk_near({e.tag, "_y"}, oy, e.y);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk_eq("ack_in_ready", int'(in_ready), 1);
    chk_eq("ack_out_valid", int'(out_valid), 0);
  endtask

  task automatic run(input int x, input int y, input int ph, input string tag,
                     output int ox, output int oy);
    int n;
    send(x, y, ph, tag);
    recv(n, ox, oy);
    chk_eq({tag, "_latency"}, n, 16);
  endtask

  initial begin
    int ox, oy, ax, ay, n, hx, hy;
    logic seen;

    #1;
    chk_eq("rst_in_ready", int'(in_ready), 1);
    chk_eq("rst_out_valid", int'(out_valid), 0);
    chk_eq("rst_busy", int'(busy), 0);
    chk_eq("rst_x_out", int'(x_out), 0);
    chk_eq("rst_y_out", int'(y_out), 0);
    #20 rst = 1'b0;
    @(posedge clk); #1;

    run(16384, 0, 0,     "ph0",   ox, oy);
    run(16384, 0, 5760,  "ph45",  ox, oy);
    run(16384, 0, 11520, "ph90",  ox, oy);
    run(16384, 0, 23040, "ph180", ox, oy);
    run(16384, 0, 34560, "ph270", ox, oy);
    run(12000, -7000, 17000, "q1_mix", ox, oy);
    run(16384, 0, 5120,  "ph40",  ax, ay);
    run(16384, 0, 51200, "ph400", ox, oy);
    chk_eq("wrap_x_equal", ox, ax);
    chk_eq("wrap_y_equal", oy, ay);

    run(-32768, -32768, 0, "sat_neg", ox, oy);
    chk_eq("sat_neg_x_sign", int'(x_out[15]), 1);
    chk_eq("sat_neg_y_sign", int'(y_out[15]), 1);

    for (int i = 0; i < 3; i++) begin
      run(int'($urandom_range(40000)) - 20000, int'($urandom_range(40000)) - 20000,
          int'($urandom_range(65535)), "rand", ox, oy);
    end

    // Output held while out_ready is low; operands offered meanwhile are dropped
    send(-9000, 15000, 40000, "hold");
    wait_valid(n);
    chk_eq("hold_latency", n, 16);
    hx = int'(x_out);
    hy = int'(y_out);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      x_in     = 16'($urandom);
      y_in     = 16'($urandom);
      phase_in = 16'($urandom);
      @(posedge clk); #1;
      chk_eq("hold_valid", int'(out_valid), 1);
      chk_eq("hold_x", int'(x_out), hx);
      chk_eq("hold_y", int'(y_out), hy);
      chk_eq("hold_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    recv(n, ox, oy);
    @(posedge clk); #1;
    chk_eq("no_stored_operand", int'(busy), 0);

    // out_ready already high before the result exists
    out_ready = 1'b1;
    send(5000, 20000, 8000, "early_ready");
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
    chk_eq("early_ready_busy", int'(busy), 1);
    chk_eq("early_ready_valid", int'(out_valid), 0);
    out_ready = 1'b0;
    recv(n, ox, oy);
    chk_eq("early_ready_latency", n, 11);

    // Reset in the middle of the rotation discards the operation
    send(16384, 0, 5760, "rst_mid");
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk_eq("rstmid_out_valid", int'(out_valid), 0);
    chk_eq("rstmid_x_out", int'(x_out), 0);
    chk_eq("rstmid_y_out", int'(y_out), 0);
    chk_eq("rstmid_in_ready", int'(in_ready), 1);
    chk_eq("rstmid_busy", int'(busy), 0);
    void'(sb.pop_back());
    #2 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    chk_eq("rstmid_no_valid", int'(seen), 0);
    run(0, 16384, 2560, "after_rst", ox, oy);

    chk_eq("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
